// File: rtl/instr_mem_loader_if.sv
// Byte-stream in / instruction-memory write port bundle for instr_mem_loader.
// slave  : the loader (consumes bytes, drives the memory write port)
// master : the host byte source plus the instruction memory
//
// Handshake: a byte is transferred on every rising clk edge where in_valid
// and in_ready are both 1. The source keeps in_data stable while in_valid=1,
// and in_ready never depends on in_valid. mem_we is a one-cycle pulse with
// no backpressure; mem_addr/mem_wd are valid whenever mem_we=1.
interface instr_mem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wd
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: receives a framed little-endian byte image (word count N,
// then N words), writes each 32-bit word to instruction memory at
// BASE_ADDR + 4*index and holds the core in reset until the image is in.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte checked in a CHK state before the core is released.
module instr_mem_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  instr_mem_loader_if.slave   bus,
  output logic                core_rst,
  output logic                done,
  output logic                err,
  output logic [2:0]          dbg_state
);

  localparam logic [31:0]     MAX_WORDS = 32'd1 << ADDR_W;
  localparam logic [ADDR_W:0] IDX_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_LOAD = 3'd1,
    S_CHK  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_AFTER_LOAD = S_CHK;
`else
  localparam state_t S_AFTER_LOAD = S_DONE;
`endif

  state_t          state;
  state_t          state_next;
  logic [1:0]      byte_cnt;
  logic [23:0]     asm_reg;      // bytes 0..2 of the word/header being built
  logic [31:0]     asm_next;     // full value once the current byte lands
  logic [ADDR_W:0] word_count;
  logic [ADDR_W:0] word_idx;
  logic [ADDR_W:0] last_idx;
  logic [31:0]     word_byte_off;
  logic            mem_we_r;
  logic [31:0]     mem_addr_r;
  logic [31:0]     mem_wd_r;
  logic            in_ready_c;
  logic            take;
  logic            restart;
  logic            last_byte;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      chk_acc;
`endif

  // New bytes enter at the top so byte k ends up in bits 8k+7:8k.
  assign asm_next      = {bus.in_data, asm_reg};
  assign last_idx      = word_count - IDX_ONE;
  assign word_byte_off = 32'(word_idx) << 2;
  assign last_byte     = (byte_cnt == 2'd3);
  assign in_ready_c    = !rst && (state == S_HDR || state == S_LOAD || state == S_CHK);
  assign take          = bus.in_valid && in_ready_c;
  assign restart       = start && (state == S_DONE || state == S_ERR);

  assign bus.in_ready  = in_ready_c;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wd    = mem_wd_r;
  // The final word's write pulse lands in the first DONE cycle, so the core
  // is released only once that pulse is over.
  assign done          = (state == S_DONE) && !mem_we_r;
  assign core_rst      = !done;
  assign err           = (state == S_ERR);
  assign dbg_state     = state;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_HDR;
    else     state <= state_next;
  end

  // Next-state decode: header validation, end of payload, checksum, restart.
  always_comb begin
    state_next = state;
    case (state)
      S_HDR: begin
        if (take && last_byte) begin
          if (asm_next == 32'd0 || asm_next > MAX_WORDS) state_next = S_ERR;
          else                                           state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (take && last_byte && word_idx == last_idx) state_next = S_AFTER_LOAD;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (take) state_next = (bus.in_data == chk_acc) ? S_DONE : S_ERR;
      end
`endif
      S_DONE, S_ERR: begin
        if (start) state_next = S_HDR;
      end
      default: state_next = S_ERR;
    endcase
  end

  // Datapath: byte assembly, word counters, memory write pulse, checksum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt   <= 2'd0;
      asm_reg    <= 24'd0;
      word_count <= '0;
      word_idx   <= '0;
      mem_we_r   <= 1'b0;
      mem_addr_r <= 32'd0;
      mem_wd_r   <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      chk_acc    <= 8'd0;
`endif
    end else begin
      mem_we_r <= 1'b0;
      if (restart) begin
        byte_cnt   <= 2'd0;
        asm_reg    <= 24'd0;
        word_count <= '0;
        word_idx   <= '0;
`ifdef LOADER_CHECKSUM_EN
        chk_acc    <= 8'd0;
`endif
      end else if (take && (state == S_HDR || state == S_LOAD)) begin
        asm_reg  <= asm_next[31:8];
        byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
        chk_acc  <= chk_acc ^ bus.in_data;
`endif
        if (last_byte) begin
          if (state == S_HDR) begin
            // Only meaningful when the header is accepted (N <= MAX_WORDS).
            word_count <= asm_next[ADDR_W:0];
            word_idx   <= '0;
          end else begin
            mem_we_r   <= 1'b1;
            mem_wd_r   <= asm_next;
            mem_addr_r <= BASE_ADDR + word_byte_off;
            word_idx   <= word_idx + IDX_ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: directed frames (T1..T6 scenarios) plus random
// images, checked against a frame-level model of the expected writes.
module tb_instr_mem_loader;

  localparam int          ADDR_W    = 10;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
  localparam int          MAX_WORDS = 1 << ADDR_W;

  logic       clk;
  logic       rst;
  logic       start;
  logic       core_rst;
  logic       done;
  logic       err;
  logic [2:0] dbg_state;

  instr_mem_loader_if bus ();

  instr_mem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus),
    .core_rst  (core_rst),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int bad_overlap = 0;

  logic [7:0]  tx_q[$];
  logic [31:0] model_words[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_wd_q[$];
  logic [31:0] got_addr_q[$];
  logic [31:0] got_wd_q[$];
  bit          exp_done;

  // Capture every write; the core must be held in reset while writing.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      got_addr_q.push_back(bus.mem_addr);
      got_wd_q.push_back(bus.mem_wd);
      if (core_rst !== 1'b1 || done !== 1'b0) bad_overlap++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame = N (LE 32-bit), N LE words, optional XOR checksum of all bytes.
  task automatic build_frame(input logic [31:0] n_hdr);
    logic [7:0] cks;
    cks = 8'h00;
    tx_q.delete();
    exp_addr_q.delete();
    exp_wd_q.delete();
    for (int b = 0; b < 4; b++) begin
      tx_q.push_back(n_hdr[8*b +: 8]);
      cks ^= n_hdr[8*b +: 8];
    end
    exp_done = (n_hdr != 0) && (n_hdr <= MAX_WORDS);
    if (exp_done) begin
      for (int i = 0; i < int'(n_hdr); i++) begin
        for (int b = 0; b < 4; b++) begin
          tx_q.push_back(model_words[i][8*b +: 8]);
          cks ^= model_words[i][8*b +: 8];
        end
        exp_addr_q.push_back(BASE_ADDR + 32'(i) * 32'd4);
        exp_wd_q.push_back(model_words[i]);
      end
`ifdef LOADER_CHECKSUM_EN
      tx_q.push_back(cks);
`endif
    end
  endtask

  task automatic set_t1();
    model_words.delete();
    model_words.push_back(32'h0050_0013);
    model_words.push_back(32'h0010_0093);
    build_frame(32'd2);
  endtask

  task automatic set_random(input int n);
    model_words.delete();
    for (int i = 0; i < n; i++) model_words.push_back($urandom);
    build_frame(32'(n));
  endtask

  // ---------------- drivers ----------------
  // Sends the first 'count' bytes of tx_q; optional idle gaps and start noise.
  task automatic send_bytes(input int count, input int gap_max, input bit start_noise);
    for (int i = 0; i < count; i++) begin
      int g;
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (g) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        start = start_noise ? 1'($urandom_range(1, 0)) : 1'b0;
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = tx_q[i];
      start = (start_noise && i != count - 1) ? 1'($urandom_range(1, 0)) : 1'b0;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    start = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got_addr_q.delete();
    got_wd_q.delete();
    bad_overlap = 0;
    check("restart_in_ready", bus.in_ready, 1'b1);
    check("restart_done", done, 1'b0);
    check("restart_err", err, 1'b0);
    check("restart_core_rst", core_rst, 1'b1);
  endtask

  task automatic wait_final(input string tag);
    int k;
    k = 0;
    while (done !== 1'b1 && err !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_timeout"}, 32'(k < 300), 32'd1);
    check({tag, "_done"}, done, exp_done);
    check({tag, "_err"}, err, !exp_done);
    check({tag, "_core_rst"}, core_rst, !exp_done);
    check({tag, "_in_ready"}, bus.in_ready, 1'b0);
    check({tag, "_overlap"}, 32'(bad_overlap), 32'd0);
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_wr_count"}, 32'(got_addr_q.size()), 32'(exp_addr_q.size()));
    for (int i = 0; i < exp_addr_q.size() && i < got_addr_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), got_addr_q[i], exp_addr_q[i]);
      check($sformatf("%s_wd%0d", tag, i), got_wd_q[i], exp_wd_q[i]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset values while rst is held.
    #3;
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wd", bus.mem_wd, 32'd0);
    check("rst_core_rst", core_rst, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1'b1);
    check("post_rst_core_rst", core_rst, 1'b1);

    // T1: two-word image, back-to-back bytes, exact release timing.
    set_t1();
    send_bytes(tx_q.size(), 0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    check("t1_done_edge", done, 1'b1);
`else
    check("t1_last_we", bus.mem_we, 1'b1);
    check("t1_done_during_we", done, 1'b0);
    check("t1_core_rst_during_we", core_rst, 1'b1);
    @(negedge clk);
    check("t1_done_after_we", done, 1'b1);
`endif
    wait_final("t1");
    compare_writes("t1");
    if (got_addr_q.size() == 2) begin
      check("t1_addr0_const", got_addr_q[0], 32'h0000_0000);
      check("t1_wd0_const", got_wd_q[0], 32'h0050_0013);
      check("t1_addr1_const", got_addr_q[1], 32'h0000_0004);
      check("t1_wd1_const", got_wd_q[1], 32'h0010_0093);
    end
    // start while done and idle-in-done behaviour
    pulse_start();

    // T2: N = 0 rejected.
    model_words.delete();
    build_frame(32'd0);
    send_bytes(tx_q.size(), 0, 1'b0);
    wait_final("t2");
    compare_writes("t2");
    pulse_start();

    // T3: N = MAX_WORDS + 1 rejected, and an all-ones count.
    build_frame(32'(MAX_WORDS + 1));
    send_bytes(tx_q.size(), 0, 1'b0);
    wait_final("t3");
    compare_writes("t3");
    pulse_start();
    build_frame(32'hFFFF_FFFF);
    send_bytes(tx_q.size(), 1, 1'b0);
    wait_final("t3b");
    compare_writes("t3b");
    pulse_start();

    // T4: T1 with random idle gaps and start noise (ignored mid-frame).
    set_t1();
    send_bytes(tx_q.size(), 5, 1'b1);
    wait_final("t4");
    compare_writes("t4");
    pulse_start();

    // Random images with gaps.
    for (int it = 0; it < 6; it++) begin
      set_random(int'($urandom_range(8, 1)));
      send_bytes(tx_q.size(), 3, 1'b1);
      wait_final($sformatf("rnd%0d", it));
      compare_writes($sformatf("rnd%0d", it));
      pulse_start();
    end

    // Boundary: exactly MAX_WORDS words (last address 4*(MAX_WORDS-1)).
    set_random(MAX_WORDS);
    send_bytes(tx_q.size(), 0, 1'b0);
    wait_final("max");
    compare_writes("max");
    pulse_start();

    // T5: reset after 6 payload bytes, then full T1 again.
    set_t1();
    send_bytes(10, 0, 1'b0);
    check("t5_prewrites", 32'(got_addr_q.size()), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_mem_we", bus.mem_we, 1'b0);
    check("t5_rst_mem_addr", bus.mem_addr, 32'd0);
    check("t5_rst_mem_wd", bus.mem_wd, 32'd0);
    check("t5_rst_in_ready", bus.in_ready, 1'b0);
    check("t5_rst_core_rst", core_rst, 1'b1);
    check("t5_rst_done", done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    got_addr_q.delete();
    got_wd_q.delete();
    bad_overlap = 0;
    @(negedge clk);
    check("t5_in_ready", bus.in_ready, 1'b1);
    send_bytes(tx_q.size(), 2, 1'b0);
    wait_final("t5");
    compare_writes("t5");
    pulse_start();

`ifdef LOADER_CHECKSUM_EN
    // T6: corrupted checksum byte -> error, words stay written.
    set_t1();
    tx_q[tx_q.size() - 1] = tx_q[tx_q.size() - 1] ^ 8'h01;
    check("t6_bad_cks_value", 32'(tx_q[tx_q.size() - 1]), 32'h0000_00C3);
    exp_done = 1'b0;
    send_bytes(tx_q.size(), 0, 1'b0);
    wait_final("t6");
    compare_writes("t6");
    pulse_start();
    set_t1();
    send_bytes(tx_q.size(), 0, 1'b0);
    wait_final("t6_ok");
    compare_writes("t6_ok");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
